// File: rtl/pc_sequencer.sv
// PC-update stage: owns the architectural PC, tracks RUN/HALT/FAULT status and
// cross-checks every ret target against a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned          ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
  parameter int unsigned          RAS_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          retire,
  input  logic                          stall,
  input  logic [3:0]                    icode,
  input  logic                          cnd,
  input  logic                          instr_valid,
  input  logic                          imem_error,
  input  logic [ADDR_W-1:0]             valC,
  input  logic [ADDR_W-1:0]             valM,
  input  logic [ADDR_W-1:0]             valP,
  output logic [ADDR_W-1:0]             PC,
  output logic [2:0]                    stat,
  output logic                          halted,
  output logic                          ras_mismatch,
  output logic [$clog2(RAS_DEPTH):0]    ras_count
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          stat_q, stat_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                mism_q, mism_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]   ras_q [RAS_DEPTH];
  logic                push;
  logic                upd;
  logic                invalid;
  logic [ADDR_W-1:0]   ras_top;

  assign upd     = (state_q == ST_RUN) && retire && !stall;
  assign invalid = !instr_valid || (icode > 4'hB);
  assign ras_top = ras_q[ptr_q - PW'(1)];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      stat_q  <= STAT_AOK;
      pc_q    <= RESET_VEC;
      mism_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      pc_q    <= pc_d;
      mism_q  <= mism_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      if (push) ras_q[ptr_q] <= valP;
    end
  end

  // Next-state logic; faults and halt leave PC and the RAS untouched
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    pc_d    = pc_q;
    mism_d  = 1'b0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    push    = 1'b0;
    if (upd) begin
      if (imem_error) begin
        state_d = ST_FAULT;
        stat_d  = STAT_ADR;
      end else if (invalid) begin
        state_d = ST_FAULT;
        stat_d  = STAT_INS;
      end else if (icode == 4'h0) begin
        state_d = ST_HALT;
        stat_d  = STAT_HLT;
      end else begin
        case (icode)
          4'h7: pc_d = cnd ? valC : valP;
          4'h8: begin
            pc_d  = valC;
            push  = 1'b1;
            ptr_d = ptr_q + PW'(1);
            if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
          end
          4'h9: begin
            // The RAS only checks; the PC always follows valM
            pc_d = valM;
            if (cnt_q == '0) begin
              mism_d = 1'b1;
            end else begin
              mism_d = (ras_top != valM);
              cnt_d  = cnt_q - CW'(1);
              ptr_d  = ptr_q - PW'(1);
            end
          end
          default: pc_d = valP;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    PC           = pc_q;
    stat         = stat_q;
    halted       = (state_q != ST_RUN);
    ras_mismatch = mism_q;
    ras_count    = cnt_q;
  end

endmodule
